// File: rtl/count_mod_chain_pkg.sv
// ============================================================================
// Module : count_mod_chain_pkg
// Brief  : Shared direction encodings, default geometry and clock presets
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package count_mod_chain_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_NCH   = 3;

    localparam int MAX_SS   = 59;
    localparam int MAX_MM   = 59;
    localparam int MAX_HH24 = 23;
    localparam int MAX_HH12 = 11;

endpackage

`default_nettype wire

// File: rtl/count_mod_chain_stage.sv
// ============================================================================
// Module : count_mod_stage
// Brief  : One WIDTH-bit up/down modulo stage with saturating load
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module count_mod_stage
    import count_mod_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] r_q;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_dn_reload;
    logic [WIDTH-1:0] w_ld_val;

    // >= rather than == so a max lowered below the current value still wraps
    assign w_at_top    = (r_q >= max);
    assign w_at_zero   = (r_q == '0);
    assign w_dn_reload = w_at_zero | (r_q > max);
    assign w_ld_val    = (d > max) ? max : d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= w_ld_val;
        end else if (en) begin
            if (up == CNT_UP) begin
                r_q <= w_at_top ? '0 : r_q + WIDTH'(1);
            end else begin
                r_q <= w_dn_reload ? max : r_q - WIDTH'(1);
            end
        end
    end

    assign q  = r_q;
    assign tc = (up == CNT_UP) ? w_at_top : w_at_zero;

endmodule

`default_nettype wire

// File: rtl/count_mod_chain.sv
// ============================================================================
// Module : count_mod_chain
// Brief  : NCH cascaded modulo stages with clock enable and ripple carry/borrow
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module count_mod_chain
    import count_mod_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 clr,
    input  logic                 up,
    input  logic                 ld,
    input  logic [NCH-1:0]       ld_sel,
    input  logic [WIDTH-1:0]     d,
    input  logic [NCH*WIDTH-1:0] max,
    output logic [NCH*WIDTH-1:0] q,
    output logic [NCH-1:0]       tc,
    output logic                 co
);

    // w_en[i] enables stage i; w_en[NCH] is the chain-wide wrap condition
    logic [NCH:0] w_en;

    assign w_en[0] = ce & ~ld;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_stage
        logic w_ld;
        assign w_ld        = ce & ld & ld_sel[gi];
        assign w_en[gi+1]  = w_en[gi] & tc[gi];

        count_mod_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (w_en[gi]),
            .ld    (w_ld),
            .up    (up),
            .d     (d),
            .max   (max[gi*WIDTH +: WIDTH]),
            .q     (q[gi*WIDTH +: WIDTH]),
            .tc    (tc[gi])
        );
    end

    assign co = w_en[NCH] & ~clr;

endmodule

`default_nettype wire

// File: tb/tb_count_mod_chain.sv
// ============================================================================
// Module : tb_count_mod_chain
// Brief  : Directed and random checks of count_mod_chain against a stage model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_count_mod_chain;
    import count_mod_chain_pkg::*;

    localparam int W = 6;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ce;
    logic           clr;
    logic           up;
    logic           ld;
    logic [N-1:0]   ld_sel;
    logic [W-1:0]   d;
    logic [N*W-1:0] max;
    logic [N*W-1:0] q;
    logic [N-1:0]   tc;
    logic           co;

    int m_q[N];
    int errors = 0;
    int checks = 0;

    count_mod_chain #(.WIDTH(W), .NCH(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .clr    (clr),
        .up     (up),
        .ld     (ld),
        .ld_sel (ld_sel),
        .d      (d),
        .max    (max),
        .q      (q),
        .tc     (tc),
        .co     (co)
    );

    always #5 clk = ~clk;

    function automatic int mx(int i);
        return int'(max[i*W +: W]);
    endfunction

    function automatic logic [N*W-1:0] hms(int h, int m, int s);
        logic [N*W-1:0] r;
        r = '0;
        r[2*W +: W] = W'(h);
        r[W   +: W] = W'(m);
        r[0   +: W] = W'(s);
        return r;
    endfunction

    function automatic logic [N*W-1:0] model_q();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_q[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] model_tc();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = up ? (m_q[i] >= mx(i)) : (m_q[i] == 0);
        return r;
    endfunction

    function automatic logic model_co();
        return ce && !ld && !clr && (&model_tc());
    endfunction

    // Stage behaviour straight from the counting rules, on plain integers
    task automatic model_edge();
        logic [N-1:0] t;
        bit           go;
        t = model_tc();
        if (clr) begin
            for (int i = 0; i < N; i++) m_q[i] = 0;
        end else if (ce && ld) begin
            for (int i = 0; i < N; i++)
                if (ld_sel[i]) m_q[i] = (int'(d) > mx(i)) ? mx(i) : int'(d);
        end else if (ce) begin
            go = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (go) begin
                    if (up) m_q[i] = (m_q[i] >= mx(i)) ? 0 : m_q[i] + 1;
                    else    m_q[i] = (m_q[i] == 0 || m_q[i] > mx(i)) ? mx(i) : m_q[i] - 1;
                end
                go = go && t[i];
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        #1;
        chk("tc", 64'(tc), 64'(model_tc()));
        chk("co", 64'(co), 64'(model_co()));
        @(posedge clk);
        model_edge();
        #1;
        chk("q", 64'(q), 64'(model_q()));
    endtask

    task automatic load(int i, int v);
        ce = 1'b1; clr = 1'b0; ld = 1'b1;
        ld_sel = N'(1) << i;
        d = W'(v);
        step();
        ld = 1'b0; ld_sel = '0;
    endtask

    task automatic set_time(int h, int m, int s);
        load(2, h); load(1, m); load(0, s);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; clr = 1'b0; up = 1'b1; ld = 1'b0;
        ld_sel = '0; d = '0;
        max = hms(MAX_HH24, MAX_MM, MAX_SS);
        for (int i = 0; i < N; i++) m_q[i] = 0;
        #12;
        chk("reset_q", 64'(q), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Roll over up
        set_time(23, 59, 59);
        ce = 1'b1; up = 1'b1;
        #1 chk("rollover_co_pre", 64'(co), 64'(1));
        step();
        chk("rollover_q", 64'(q), 64'(hms(0, 0, 0)));
        chk("rollover_co_post", 64'(co), 64'(0));

        // Borrow down
        up = 1'b0;
        #1 chk("borrow_tc", 64'(tc), 64'(3'b111));
        chk("borrow_co", 64'(co), 64'(1));
        step();
        chk("borrow_q", 64'(q), 64'(hms(23, 59, 59)));

        // Saturating load: d above both 59 terminals
        clr = 1'b1; ce = 1'b0; step(); clr = 1'b0;
        ce = 1'b0; ld = 1'b1; ld_sel = 3'b011; d = 6'd63;
        step();
        chk("load_ce0_q", 64'(q), 64'(hms(0, 0, 0)));
        ce = 1'b1;
        step();
        chk("sat_load_q", 64'(q), 64'(hms(0, 59, 59)));
        ld = 1'b0; ld_sel = '0;

        // Clear with ce low, then hold
        set_time(12, 34, 56);
        ce = 1'b0; clr = 1'b1; up = 1'b1;
        step();
        chk("clear_q", 64'(q), 64'(hms(0, 0, 0)));
        set_time(12, 34, 56);
        ce = 1'b0; clr = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("hold_q", 64'(q), 64'(hms(12, 34, 56)));

        // Async reset between edges
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) m_q[i] = 0;
        chk("async_rst_q", 64'(q), 64'(hms(0, 0, 0)));
        #1 rst_n = 1'b1;
        ce = 1'b1; up = 1'b1;
        step();
        chk("after_rst_q", 64'(q), 64'(hms(0, 0, 1)));

        // Shrunken max
        set_time(0, 0, 45);
        max[0 +: W] = 6'd30; ce = 1'b1; up = 1'b1;
        step();
        chk("shrunk_up_q", 64'(q), 64'(hms(0, 1, 0)));
        max[0 +: W] = 6'd59;
        load(0, 45);
        max[0 +: W] = 6'd30; ce = 1'b1; up = 1'b0;
        step();
        chk("shrunk_dn_q0", 64'(q[0 +: W]), 64'(30));

        // Zero terminal is transparent to the carry
        max = hms(3, 0, 2);
        clr = 1'b1; step(); clr = 1'b0;
        ce = 1'b1; up = 1'b1;
        for (int k = 0; k < 8; k++) step();

        // Random traffic, small terminals so wraps are frequent
        for (int k = 0; k < 400; k++) begin
            ce  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            ld_sel = N'($urandom);
            d   = W'($urandom);
            if ($urandom_range(0, 15) == 0) up = ~up;
            if ($urandom_range(0, 31) == 0) begin
                for (int i = 0; i < N; i++)
                    max[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
